// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer: FSM states, shift modes
// and shift-amount saturation.
package shift_seq_pkg;
    localparam int WIDTH     = 32;
    localparam int SHAMT_SAT = 32;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    // Modes are packed as {lrbar, albar}
    typedef logic [1:0] mode_t;
    localparam mode_t SRA  = 2'b11;
    localparam mode_t SRL  = 2'b10;
    localparam mode_t SLL  = 2'b00;
    localparam mode_t PASS = 2'b01;

    // Any amount of WIDTH or more behaves exactly like a full WIDTH-bit shift
    function automatic logic [5:0] sat_shamt(input logic [31:0] shamt);
        return (|shamt[31:5]) ? 6'(SHAMT_SAT) : {1'b0, shamt[4:0]};
    endfunction
endpackage

// File: rtl/shift_sequencer_if.sv
// Request, response and handshake bundle between the two requesters, the
// shift sequencer and the writeback consumer.
interface shift_sequencer_if;
    import shift_seq_pkg::*;

    logic             r0_valid;
    logic             r0_ready;
    logic [WIDTH-1:0] r0_in;
    logic [31:0]      r0_shamt;
    logic             r0_lrbar;
    logic             r0_albar;
    logic             r1_valid;
    logic             r1_ready;
    logic [WIDTH-1:0] r1_in;
    logic [31:0]      r1_shamt;
    logic             r1_lrbar;
    logic             r1_albar;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_id;

    modport master (
        output r0_valid, r0_in, r0_shamt, r0_lrbar, r0_albar,
        output r1_valid, r1_in, r1_shamt, r1_lrbar, r1_albar,
        output out_ready,
        input  r0_ready, r1_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  r0_valid, r0_in, r0_shamt, r0_lrbar, r0_albar,
        input  r1_valid, r1_in, r1_shamt, r1_lrbar, r1_albar,
        input  out_ready,
        output r0_ready, r1_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/shift_sequencer_step.sv
// One bounded shift step: shifts the operand by k bits in the given mode.
// Purely combinational.
module shift_step
    import shift_seq_pkg::*;
(
    input  logic signed [WIDTH-1:0] i_data,
    input  logic        [5:0]       i_k,
    input  mode_t                   i_mode,
    output logic signed [WIDTH-1:0] o_data
);
    always_comb begin
        o_data = i_data;
        case (i_mode)
            SRA:     o_data = i_data >>> i_k;
            SRL:     o_data = i_data >> i_k;
            SLL:     o_data = i_data << i_k;
            default: o_data = i_data;
        endcase
    end
endmodule

// File: rtl/shift_sequencer.sv
// Round-robin shared iterative shifter: accepts one request from r0/r1, shifts
// it STEP bits per cycle, and holds the result until the consumer takes it.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic               clk,
    input  logic               rst,
    shift_sequencer_if.slave   bus,
    output logic               busy
);
    localparam logic [5:0] STEP_K = 6'(STEP);

    state_e                  r_state;
    state_e                  w_next;
    logic signed [WIDTH-1:0] r_data;
    logic [5:0]              r_rem;
    mode_t                   r_mode;
    logic                    r_id;
    logic                    r_prio;

    logic                    w_req;
    logic                    w_grant1;
    logic signed [WIDTH-1:0] w_sel_in;
    logic [5:0]              w_sel_rem;
    mode_t                   w_sel_mode;
    logic [5:0]              w_k;
    logic [5:0]              w_rem_nxt;
    logic signed [WIDTH-1:0] w_shifted;

    // r1 wins only when it is alone or it holds priority
    assign w_req      = bus.r0_valid | bus.r1_valid;
    assign w_grant1   = bus.r1_valid & (~bus.r0_valid | r_prio);
    assign w_sel_in   = w_grant1 ? bus.r1_in : bus.r0_in;
    assign w_sel_rem  = sat_shamt(w_grant1 ? bus.r1_shamt : bus.r0_shamt);
    assign w_sel_mode = w_grant1 ? {bus.r1_lrbar, bus.r1_albar}
                                 : {bus.r0_lrbar, bus.r0_albar};

    assign bus.r0_ready = ~rst & (r_state == IDLE) & bus.r0_valid & ~w_grant1;
    assign bus.r1_ready = ~rst & (r_state == IDLE) & w_grant1;

    assign w_k       = (r_rem < STEP_K) ? r_rem : STEP_K;
    assign w_rem_nxt = r_rem - w_k;

    shift_step u_step (
        .i_data (r_data),
        .i_k    (w_k),
        .i_mode (r_mode),
        .o_data (w_shifted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_next = (w_sel_mode == PASS || w_sel_rem == 6'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (w_rem_nxt == 6'd0) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_rem  <= '0;
            r_mode <= SLL;
            r_id   <= 1'b0;
            r_prio <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_data <= w_sel_in;
                        r_rem  <= w_sel_rem;
                        r_mode <= w_sel_mode;
                        r_id   <= w_grant1;
                        r_prio <= ~w_grant1;
                    end
                end
                SHIFT: begin
                    r_data <= w_shifted;
                    r_rem  <= w_rem_nxt;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid = (r_state == DONE);
    assign bus.out_data  = r_data;
    assign bus.out_id    = r_id;
    assign busy          = (r_state != IDLE);
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Shares one iterative 32-bit shift engine between two requesters (r0, r1) using a valid/ready handshake and round-robin arbitration. Each shift is executed as a sequence of bounded steps of at most STEP bits per cycle, which trades latency for area against a full barrel shifter. Shift semantics match the core's shift datapath: lrbar=1/albar=1 is arithmetic right, lrbar=1/albar=0 is logical right, lrbar=0/albar=0 is logical left, lrbar=0/albar=1 is pass-through. The block sits between the ALU/issue logic and the writeback path.

Parameters:
STEP, 4, maximum bits shifted per cycle; must be a power of two, 1..32
WIDTH, 32, data width; fixed at 32 (the shift-amount saturation point equals WIDTH)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
r0_valid  input  1  requester 0 has a request
r0_ready  output  1  requester 0 accepted this cycle when high with r0_valid
r0_in  input  32  operand, treated as signed
r0_shamt  input  32  shift amount, unsigned
r0_lrbar  input  1  1 = right, 0 = left
r0_albar  input  1  1 = arithmetic, 0 = logical
r1_valid, r1_ready, r1_in, r1_shamt, r1_lrbar, r1_albar  same widths and directions, requester 1
out_valid  output  1  result available
out_ready  input  1  consumer takes the result
out_data  output  32  shift result
out_id  output  1  requester index that owns out_data
busy  output  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, SHIFT, DONE.
- Reset values: state=IDLE, out_valid=0, out_data=0, out_id=0, busy=0, prio=0 (r0 favoured). r0_ready and r1_ready are both 0 during reset.
- IDLE arbitration:
  - rX_ready is asserted combinationally only in IDLE, and only for the granted requester.
  - Grant goes to the sole valid requester; if both are valid, it goes to prio.
  - On accept: capture in, lrbar, albar, and id; set prio to the non-granted index.
  - remaining = 32 if shamt >= 32 (any bit above bit 5 set, or value 32..63), else shamt[4:0].
- IDLE next state:
  - Pass-through (lrbar=0, albar=1) or remaining=0 → DONE, with data = operand unchanged.
  - Otherwise → SHIFT.
- SHIFT: each cycle, k = min(remaining, STEP).
  - data is shifted by k in the captured direction and mode; arithmetic right fills with the sign bit.
  - remaining -= k; when the result is 0, go to DONE with the final data.
- Saturation results: shamt >= 32 gives 0 for logical left/right and all-sign-bits for arithmetic right. This falls out naturally from the stepping.
- Latency: out_valid rises 1 + ceil(remaining/STEP) cycles after the accept edge. Pass-through and zero-shift take 1 cycle.
- DONE:
  - out_valid=1; out_data and out_id stay stable until out_ready=1.
  - On the out_ready handshake, go to IDLE and clear out_valid.
  - A new accept happens at the earliest in the following cycle; there is no bypass, so peak throughput is one result per 2+ cycles.
- Requests are not queued: an unaccepted requester must hold valid and operands stable. Operand changes while valid and unaccepted are legal and are sampled only at accept.
- Reset mid-operation: the in-flight shift is abandoned, no output is produced, and all state returns to reset values on the next edge.
- out_ready while not in DONE is ignored.

Decomposition:
- Package shift_seq_pkg: state enum {IDLE, SHIFT, DONE}; mode constants (SRA=2'b11, SRL=2'b10, SLL=2'b00, PASS=2'b01, packed as {lrbar, albar}); SHAMT_SAT=32.
- Sub-module shift_step: purely combinational; inputs data, k (6 bits), mode; output is data shifted by k. Instantiated once.
- The top level holds the arbiter, FSM, and counters.

Test Plan:
- r0: in=0x8000_0000, shamt=4, SRA, STEP=4 → out_data=0xF800_0000, out_id=0, out_valid 2 cycles after accept.
- r1: in=0x0000_00F0, shamt=5, SLL → out_data=0x0000_1E00, out_id=1, latency 3.
- Both valid from reset, each holding valid until accepted → r0 served first then r1; repeat with both valid → r0 then r1 again (prio alternates after each grant).
- shamt=40, in=0xFFFF_FFFF: SRL → 0x0000_0000; SRA → 0xFFFF_FFFF; SLL → 0x0000_0000; each with latency 9.
- PASS with shamt=7, in=0x1234_5678 → out_data 0x1234_5678, latency 1. SRL with shamt=0 → same value, latency 1.
- out_ready held low 5 cycles in DONE → out_valid, out_data, out_id stable and r0/r1_ready=0. Separately, assert rst during SHIFT → out_valid=0 and busy=0 next cycle, and the next request behaves as if from reset.
